// File: rtl/alu64_seq_issuer_pkg.sv
// Shared encodings for the 64-bit ALU sequencer: op codes, FSM states, half width.
package alu_seq_pkg;

  localparam int HALF_W = 32;
  localparam int FULL_W = 2 * HALF_W;
  localparam logic [1:0] IDLE_OP_DEF = 2'b10;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_ILL = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    FIX  = 3'd3,
    RESP = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu64_seq_issuer_if.sv
// Request/response handshake and 32-bit ALU side-channel of the sequencer.
interface alu64_seq_issuer_if
  import alu_seq_pkg::*;
#(
  parameter int W = HALF_W
);

  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_a;
  logic [2*W-1:0] in_b;
  logic [1:0]     in_op;

  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_result;
  logic           out_carry;
  logic           out_err;

  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [1:0]     alu_op;
  logic [W-1:0]   alu_result;
  logic           alu_carry;

  // Sequencer view.
  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready, alu_result, alu_carry,
    output in_ready, out_valid, out_result, out_carry, out_err, alu_a, alu_b, alu_op
  );

  // Execute-stage controller plus ALU view.
  modport master (
    output in_valid, in_a, in_b, in_op, out_ready, alu_result, alu_carry,
    input  in_ready, out_valid, out_result, out_carry, out_err, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/alu_32bit.sv
// Existing combinational 32-bit ALU: add (carry), sub (borrow), and.
module alu_32bit #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [W:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      2'b00: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[W-1:0];
        carry  = wide[W];
      end
      2'b01: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[W-1:0];
        carry  = wide[W];
      end
      2'b10: result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu64_seq_issuer.sv
// Splits 64-bit add/sub/and into 32-bit ALU passes with carry/borrow chaining.
// Optional macro ALU_SEQ_FASTFIX_EN skips the FIX pass when the low half produced no carry.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// LO    | low halves on the ALU
// HI    | high halves on the ALU
// FIX   | high result adjusted by the low-half carry/borrow
// RESP  | response held until out_ready
module alu64_seq_issuer
  import alu_seq_pkg::*;
#(
  parameter int         HALF_W  = 32,
  parameter logic [1:0] IDLE_OP = 2'b10
) (
  input logic clk,
  input logic rst,
  alu64_seq_issuer_if.slave bus
);

  seq_state_e          state_q;
  alu_op_e             op_q;
  logic [HALF_W-1:0]   a_hi_q;
  logic [HALF_W-1:0]   b_hi_q;
  logic [HALF_W-1:0]   res_lo_q;
  logic                c1_q;
  logic                c2_q;
  logic [HALF_W-1:0]   alu_a_q;
  logic [HALF_W-1:0]   alu_b_q;
  logic [1:0]          alu_op_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [2*HALF_W-1:0] out_result_q;
  logic                out_carry_q;
  logic                out_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_AND;
      a_hi_q       <= '0;
      b_hi_q       <= '0;
      res_lo_q     <= '0;
      c1_q         <= 1'b0;
      c2_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= IDLE_OP;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            op_q       <= alu_op_e'(bus.in_op);
            a_hi_q     <= bus.in_a[2*HALF_W-1:HALF_W];
            b_hi_q     <= bus.in_b[2*HALF_W-1:HALF_W];
            if (bus.in_op == OP_ILL) begin
              state_q      <= RESP;
              out_valid_q  <= 1'b1;
              out_result_q <= '0;
              out_carry_q  <= 1'b0;
              out_err_q    <= 1'b1;
            end else begin
              state_q  <= LO;
              alu_a_q  <= bus.in_a[HALF_W-1:0];
              alu_b_q  <= bus.in_b[HALF_W-1:0];
              alu_op_q <= bus.in_op;
            end
          end
        end

        LO: begin
          res_lo_q <= bus.alu_result;
          c1_q     <= bus.alu_carry;
          alu_a_q  <= a_hi_q;
          alu_b_q  <= b_hi_q;
          state_q  <= HI;
        end

        HI: begin
          c2_q <= bus.alu_carry;
          if (op_q == OP_AND) begin
            state_q      <= RESP;
            out_valid_q  <= 1'b1;
            out_result_q <= {bus.alu_result, res_lo_q};
            out_carry_q  <= 1'b0;
            out_err_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= IDLE_OP;
          end
`ifdef ALU_SEQ_FASTFIX_EN
          else if (!c1_q) begin
            state_q      <= RESP;
            out_valid_q  <= 1'b1;
            out_result_q <= {bus.alu_result, res_lo_q};
            out_carry_q  <= bus.alu_carry;
            out_err_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= IDLE_OP;
          end
`endif
          else begin
            // Same op again: add the low carry in, or subtract the low borrow.
            state_q <= FIX;
            alu_a_q <= bus.alu_result;
            alu_b_q <= {{(HALF_W-1){1'b0}}, c1_q};
          end
        end

        FIX: begin
          state_q      <= RESP;
          out_valid_q  <= 1'b1;
          out_result_q <= {bus.alu_result, res_lo_q};
          out_carry_q  <= c2_q | bus.alu_carry;
          out_err_q    <= 1'b0;
          alu_a_q      <= '0;
          alu_b_q      <= '0;
          alu_op_q     <= IDLE_OP;
        end

        RESP: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          alu_op_q    <= IDLE_OP;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_carry  = out_carry_q;
  assign bus.out_err    = out_err_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;

endmodule

// File: tb/tb_alu64_seq_issuer.sv
// Scoreboard bench for alu64_seq_issuer driving a real alu_32bit alongside it.
module tb_alu64_seq_issuer;

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        e;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;
  exp_t sb[$];

  alu64_seq_issuer_if #(.W(32)) bus ();

  alu64_seq_issuer #(.HALF_W(32), .IDLE_OP(2'b10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_32bit #(.W(32)) u_alu (
    .a      (bus.alu_a),
    .b      (bus.alu_b),
    .op     (bus.alu_op),
    .result (bus.alu_result),
    .carry  (bus.alu_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    exp_t        x;
    logic [64:0] s;
    logic [32:0] lo;
    logic [31:0] alo;
    logic [31:0] blo;
    logic        c1;
    alo = a[31:0];
    blo = b[31:0];
    x.e = 1'b0;
    c1  = 1'b0;
    case (op)
      2'b00: begin
        s    = {1'b0, a} + {1'b0, b};
        x.res = s[63:0];
        x.c   = s[64];
        lo   = {1'b0, alo} + {1'b0, blo};
        c1   = lo[32];
        x.lat = 4;
      end
      2'b01: begin
        x.res = a - b;
        x.c   = (a < b);
        c1    = (alo < blo);
        x.lat = 4;
      end
      2'b10: begin
        x.res = a & b;
        x.c   = 1'b0;
        x.lat = 3;
      end
      default: begin
        x.res = '0;
        x.c   = 1'b0;
        x.e   = 1'b1;
        x.lat = 1;
      end
    endcase
`ifdef ALU_SEQ_FASTFIX_EN
    if (op[1] == 1'b0 && !c1) x.lat = 3;
`endif
    sb.push_back(x);
  endtask

  // Called at a negedge; returns at the first negedge after the accept edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    int w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", {63'b0, bus.in_ready}, 64'd1);
    push_exp(a, b, op);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
  endtask

  task automatic wait_resp(input string tag);
    int   lat = 1;
    exp_t x;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, {63'b0, bus.out_valid}, 64'd1);
    if (bus.out_valid && sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, "_res"}, bus.out_result, x.res);
      chk({tag, "_carry"}, {63'b0, bus.out_carry}, {63'b0, x.c});
      chk({tag, "_err"}, {63'b0, bus.out_err}, {63'b0, x.e});
      chk({tag, "_lat"}, 64'(lat), 64'(x.lat));
      chk({tag, "_busy"}, {63'b0, bus.in_ready}, 64'd0);
    end
  endtask

  task automatic finish_hs(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_vld_drop"}, {63'b0, bus.out_valid}, 64'd0);
    chk({tag, "_rdy_back"}, {63'b0, bus.in_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op);
    issue(a, b, op);
    wait_resp(tag);
    finish_hs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;
    logic        seen;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 2'b00;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_result", bus.out_result, 64'd0);
    chk("rst_carry", {63'b0, bus.out_carry}, 64'd0);
    chk("rst_err", {63'b0, bus.out_err}, 64'd0);
    chk("rst_alu_op", {62'b0, bus.alu_op}, 64'd2);
    chk("rst_alu_a", {32'b0, bus.alu_a}, 64'd0);
    chk("rst_alu_b", {32'b0, bus.alu_b}, 64'd0);

    run_op("add_lo_carry", 64'h0000_0000_FFFF_FFFF, 64'h1, 2'b00);
    run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00);
    run_op("add_nocarry", 64'h1234_5678_0000_0001, 64'h1111_1111_0000_0002, 2'b00);
    run_op("sub_borrow_lo", 64'h0000_0001_0000_0000, 64'h1, 2'b01);
    run_op("sub_zero_one", 64'h0, 64'h1, 2'b01);
    run_op("sub_equal", 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 2'b01);
    run_op("and", 64'hF0F0_F0F0_1234_5678, 64'hFF00_FF00_FFFF_0000, 2'b10);
    run_op("illegal", 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 2'b11);

    // Backpressure: response must hold while out_ready is low.
    bus.out_ready = 1'b0;
    issue(64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 2'b00);
    wait_resp("bp");
    held = bus.out_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {63'b0, bus.out_valid}, 64'd1);
      chk("bp_hold_result", bus.out_result, held);
      chk("bp_hold_in_ready", {63'b0, bus.in_ready}, 64'd0);
    end
    finish_hs("bp");
    run_op("after_bp", 64'h7, 64'h9, 2'b01);

    for (int i = 0; i < 8; i++) begin
      run_op("rand", {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
    end

    // Reset while the high halves are on the ALU: op vanishes without a response.
    bus.in_a     = 64'h0000_0000_FFFF_FFFF;
    bus.in_b     = 64'h1;
    bus.in_op    = 2'b00;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("abort_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("abort_alu_op", {62'b0, bus.alu_op}, 64'd2);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_resp", {63'b0, seen}, 64'd0);
    run_op("post_abort", 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 2'b00);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
